// File: rtl/tex_fill_engine.sv
// tex_fill_engine
// Command-driven rectangle filler for the 60x40 word texture buffer that the
// VGA display scans. It is a second writer of that buffer beside dmem, so an
// external arbiter grants its write port and CPU stores keep priority.
// Supported fills are solid and two-colour checkerboard, clipped at the
// right and bottom edges of the buffer.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; accepted only while idle
//   cmd_x/y/w/h         rectangle origin (column, row) and size in words/rows
//   cmd_mode            0 = solid color0, 1 = checkerboard on parity of (x+y)
//   cmd_color0/1        fill colours
//   abort               ends the current command with err = 1
//   tex_we/addr/wdata   write request; a word completes when tex_we && tex_gnt
//   tex_gnt             arbiter grant
//   busy                command in SETUP or WRITE
//   done, err           one-cycle completion pulse, err = rejected or aborted
//   words_written       granted writes for the last or current command
module tex_fill_engine #(
  parameter int COLS = 60,
  parameter int ROWS = 40,
  parameter int AW   = 12,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [6:0]    cmd_x,
  input  logic [6:0]    cmd_y,
  input  logic [6:0]    cmd_w,
  input  logic [6:0]    cmd_h,
  input  logic          cmd_mode,
  input  logic [DW-1:0] cmd_color0,
  input  logic [DW-1:0] cmd_color1,
  input  logic          abort,
  output logic          tex_we,
  output logic [AW-1:0] tex_addr,
  output logic [DW-1:0] tex_wdata,
  input  logic          tex_gnt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [11:0]   words_written
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [6:0]    COLS_C     = 7'(COLS);
  localparam logic [6:0]    ROWS_C     = 7'(ROWS);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(COLS);

  logic [1:0]    state_q, state_d;
  logic [6:0]    x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] color0_q, color0_d, color1_q, color1_d;
  logic [6:0]    eff_w_q, eff_w_d, eff_h_q, eff_h_d;
  logic [6:0]    col_q, col_d, row_q, row_d;
  logic [AW-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [11:0]   words_q, words_d;

  // Setup-time values derived from the latched command.
  logic          reject;
  logic [6:0]    rem_w, rem_h;
  logic [AW-1:0] base;

  // Position bookkeeping for the word after the one currently offered.
  logic          row_end, last_word, next_parity;
  logic [6:0]    next_col, next_row;
  logic [AW-1:0] next_addr;

  assign reject = (x_q >= COLS_C) || (y_q >= ROWS_C) || (w_q == 7'd0) || (h_q == 7'd0);
  assign rem_w  = COLS_C - x_q;
  assign rem_h  = ROWS_C - y_q;
  assign base   = AW'(y_q) * ROW_STRIDE + AW'(x_q);

  // Addresses advance incrementally: +1 within a row, row start +COLS at wrap.
  assign row_end     = (col_q == eff_w_q - 7'd1);
  assign last_word   = row_end && (row_q == eff_h_q - 7'd1);
  assign next_col    = row_end ? 7'd0 : col_q + 7'd1;
  assign next_row    = row_end ? row_q + 7'd1 : row_q;
  assign next_addr   = row_end ? row_base_q + ROW_STRIDE : addr_q + AW'(1);
  // Parity of absolute (x+y) only needs the low bits of origin and offsets.
  assign next_parity = x_q[0] ^ y_q[0] ^ next_col[0] ^ next_row[0];

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    mode_d     = mode_q;
    color0_d   = color0_q;
    color1_d   = color1_q;
    eff_w_d    = eff_w_q;
    eff_h_d    = eff_h_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    words_d    = words_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          x_d      = cmd_x;
          y_d      = cmd_y;
          w_d      = cmd_w;
          h_d      = cmd_h;
          mode_d   = cmd_mode;
          color0_d = cmd_color0;
          color1_d = cmd_color1;
          words_d  = 12'd0;
          err_d    = 1'b0;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        eff_w_d    = (w_q < rem_w) ? w_q : rem_w;
        eff_h_d    = (h_q < rem_h) ? h_q : rem_h;
        col_d      = 7'd0;
        row_d      = 7'd0;
        row_base_d = base;
        addr_d     = base;
        wdata_d    = (mode_q && (x_q[0] ^ y_q[0])) ? color1_q : color0_q;
        if (abort || reject) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (tex_gnt) begin
          words_d = words_q + 12'd1;
          if (last_word) begin
            err_d   = 1'b0;
            state_d = ST_FINISH;
          end else begin
            col_d   = next_col;
            row_d   = next_row;
            addr_d  = next_addr;
            wdata_d = (mode_q && next_parity) ? color1_q : color0_q;
            if (row_end) begin
              row_base_d = next_addr;
            end
          end
        end
        // Abort wins over a coinciding grant; the granted word still counts.
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      mode_q     <= 1'b0;
      color0_q   <= '0;
      color1_q   <= '0;
      eff_w_q    <= '0;
      eff_h_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      mode_q     <= mode_d;
      color0_q   <= color0_d;
      color1_q   <= color1_d;
      eff_w_q    <= eff_w_d;
      eff_h_q    <= eff_h_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      words_q    <= words_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign tex_we        = (state_q == ST_WRITE);
  assign busy          = (state_q == ST_SETUP) || (state_q == ST_WRITE);
  assign done          = (state_q == ST_FINISH);
  assign err           = done && err_q;
  assign tex_addr      = addr_q;
  assign tex_wdata     = wdata_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_tex_fill_engine.sv
// tb_tex_fill_engine
// Self-checking bench for tex_fill_engine. Each command is expanded by a
// reference model into the list of (address, data) writes it should produce,
// computed directly from rectangle geometry, clipping and colour rules.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_tex_fill_engine;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic        cmd_mode;
  logic [31:0] cmd_color0, cmd_color1;
  logic        abort;
  logic        tex_we;
  logic [11:0] tex_addr;
  logic [31:0] tex_wdata;
  logic        tex_gnt;
  logic        busy, done, err;
  logic [11:0] words_written;

  int checkCount = 0;
  int errorCount = 0;

  tex_fill_engine dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_mode(cmd_mode), .cmd_color0(cmd_color0), .cmd_color1(cmd_color1),
    .abort(abort),
    .tex_we(tex_we), .tex_addr(tex_addr), .tex_wdata(tex_wdata), .tex_gnt(tex_gnt),
    .busy(busy), .done(done), .err(err), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Issues one command and follows it to completion.
  // gntMode: 0 = grant every cycle, 1 = random grant, 2 = fixed pattern 1,0,0,1,0,1.
  // abortAt: -1 none, -2 abort during SETUP, n >= 0 abort together with grant n.
  task automatic applyStimulus(input int x, input int y, input int w, input int h,
                               input logic mode, input logic [31:0] c0, input logic [31:0] c1,
                               input int gntMode, input int abortAt);
    int expAddr[$];
    logic [31:0] expData[$];
    int effW, effH, cycle, idx, firstWe, lastGrant, doneCycle, patIdx, expWords;
    bit rejected, aborted, gnt;
    bit pattern[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rejected = (x >= 60) || (y >= 40) || (w == 0) || (h == 0);
    if (!rejected) begin
      effW = (w < 60 - x) ? w : 60 - x;
      effH = (h < 40 - y) ? h : 40 - y;
      for (int r = 0; r < effH; r++) begin
        for (int c = 0; c < effW; c++) begin
          expAddr.push_back((y + r) * 60 + (x + c));
          expData.push_back((mode && (((x + c + y + r) % 2) == 1)) ? c1 : c0);
        end
      end
    end

    @(negedge clk);
    checkOutput("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_x = 7'(x); cmd_y = 7'(y); cmd_w = 7'(w); cmd_h = 7'(h);
    cmd_mode = mode; cmd_color0 = c0; cmd_color1 = c1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cycle = 1; idx = 0; firstWe = -1; lastGrant = -1; doneCycle = -1;
    patIdx = 0; aborted = 1'b0; expWords = expAddr.size();

    while (cycle < 4000) begin
      if (done) begin
        doneCycle = cycle;
        break;
      end
      checkOutput("busy", {31'd0, busy}, 32'd1);
      checkOutput("ready_busy", {31'd0, cmd_ready}, 32'd0);
      // Commands offered while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_x = 7'($urandom_range(0, 127));
      if (cycle == 1 && abortAt == -2) begin
        abort = 1'b1;
        aborted = 1'b1;
        expWords = 0;
      end
      if (tex_we) begin
        if (firstWe < 0) firstWe = cycle;
        if (aborted || idx >= expAddr.size()) begin
          checkOutput("extra_we", {31'd0, tex_we}, 32'd0);
          gnt = 1'b0;
        end else begin
          checkOutput("addr", {20'd0, tex_addr}, 32'(expAddr[idx]));
          checkOutput("wdata", tex_wdata, expData[idx]);
          case (gntMode)
            0:       gnt = 1'b1;
            1:       gnt = ($urandom_range(0, 3) != 0);
            default: begin
              gnt = (patIdx < 6) ? pattern[patIdx] : 1'b1;
              patIdx++;
            end
          endcase
        end
        tex_gnt = gnt;
        if (gnt) begin
          if (idx == abortAt) begin
            abort = 1'b1;
            aborted = 1'b1;
            expWords = idx + 1;
          end
          idx++;
          lastGrant = cycle;
        end
      end else begin
        // A grant with no request must not count as a write.
        tex_gnt = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      abort = 1'b0;
      tex_gnt = 1'b0;
      cycle++;
    end
    cmd_valid = 1'b0;

    checkOutput("done_seen", {31'd0, done}, 32'd1);
    checkOutput("err", {31'd0, err}, {31'd0, (rejected || aborted)});
    checkOutput("words_written", {20'd0, words_written}, 32'(expWords));
    checkOutput("we_at_done", {31'd0, tex_we}, 32'd0);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    if (rejected || abortAt == -2) begin
      checkOutput("done_cycle_setup", 32'(doneCycle), 32'd2);
      checkOutput("no_write_first", 32'(firstWe), 32'hFFFF_FFFF);
    end else begin
      checkOutput("first_we_cycle", 32'(firstWe), 32'd2);
      checkOutput("done_after_grant", 32'(doneCycle), 32'(lastGrant + 1));
      if (gntMode == 0 && !aborted)
        checkOutput("done_latency", 32'(doneCycle), 32'(2 + expAddr.size()));
    end

    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd0);
    checkOutput("ready_after", {31'd0, cmd_ready}, 32'd1);
    checkOutput("words_hold", {20'd0, words_written}, 32'(expWords));
  endtask

  initial begin
    int waitCycles;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_mode = 1'b0; cmd_color0 = '0; cmd_color1 = '0;
    abort = 1'b0; tex_gnt = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_we", {31'd0, tex_we}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_addr", {20'd0, tex_addr}, 32'd0);
    checkOutput("rst_wdata", tex_wdata, 32'd0);
    checkOutput("rst_words", {20'd0, words_written}, 32'd0);
    reset = 1'b1;

    // Abort while idle is ignored.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle_abort_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("idle_abort_busy", {31'd0, busy}, 32'd0);

    $display("[TB] directed commands");
    applyStimulus(2, 3, 4, 2, 1'b0, 32'hDEADBEEF, 32'h12345678, 0, -1);
    applyStimulus(0, 0, 2, 2, 1'b1, 32'h0, 32'hFFFFFFFF, 0, -1);
    applyStimulus(58, 39, 10, 5, 1'b0, 32'hA5A5A5A5, 32'h0, 0, -1);
    applyStimulus(60, 0, 1, 1, 1'b0, 32'h1, 32'h2, 0, -1);
    applyStimulus(5, 5, 0, 1, 1'b0, 32'h1, 32'h2, 0, -1);
    applyStimulus(3, 7, 2, 0, 1'b1, 32'h1, 32'h2, 0, -1);
    applyStimulus(0, 40, 3, 3, 1'b0, 32'h1, 32'h2, 0, -1);
    applyStimulus(0, 0, 3, 1, 1'b0, 32'hCAFEF00D, 32'h0, 2, -1);
    applyStimulus(10, 10, 4, 4, 1'b1, 32'h11111111, 32'h22222222, 0, 4);
    applyStimulus(7, 1, 3, 3, 1'b0, 32'h33333333, 32'h0, 0, -2);
    applyStimulus(1, 2, 5, 3, 1'b1, 32'h44444444, 32'h55555555, 1, -1);

    $display("[TB] reset during write");
    @(negedge clk);
    cmd_x = 7'd4; cmd_y = 7'd4; cmd_w = 7'd4; cmd_h = 7'd4;
    cmd_mode = 1'b0; cmd_color0 = 32'h77777777; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    waitCycles = 0;
    while (!tex_we && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("reset_test_we", {31'd0, tex_we}, 32'd1);
    tex_gnt = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_we", {31'd0, tex_we}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_addr", {20'd0, tex_addr}, 32'd0);
    checkOutput("midrst_words", {20'd0, words_written}, 32'd0);
    @(negedge clk);
    checkOutput("midrst_held_we", {31'd0, tex_we}, 32'd0);
    tex_gnt = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("midrst_we_after", {31'd0, tex_we}, 32'd0);

    $display("[TB] randomized commands");
    for (int n = 0; n < 40; n++) begin
      int rx, ry, rw, rh, gm, ab;
      rx = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 59);
      ry = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 127) : $urandom_range(0, 39);
      rw = $urandom_range(0, 12);
      rh = $urandom_range(0, 6);
      gm = $urandom_range(0, 1);
      ab = ($urandom_range(0, 7) == 0) ? 0 : -1;
      applyStimulus(rx, ry, rw, rh, 1'($urandom_range(0, 1)), $urandom, $urandom, gm, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
